id_ex_pipe_stage: RTL and testbench
===================================

# id_ex_pipe_stage

Parametrised decode-to-execute pipeline stage. It carries instruction word, both register operands, immediate and instruction type from ID to EX. A valid/ready handshake replaces the free-running capture, so the stage supports back-pressure. It adds synchronous flush for branch redirect, NOP bubble insertion, and an optional skid entry that keeps `in_ready` fully registered.

## Interface
- `XLEN`, default 32: width of instruction, operand A (rs1), operand B (rs2) and immediate fields.
- `TYPE_W`, default 5: width of instruction-type field.
- `NOP_INST`, default 32'h0000_0013: instruction word presented while the stage holds a bubble.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `flush`  input  1  synchronous kill of all held and incoming entries.
- `in_valid`  input  1  ID presents an entry.
- `in_ready`  output  1  stage accepts an entry this cycle.
- `in_inst`, `in_op_a`, `in_op_b`, `in_imm`  input  XLEN each  decode payload.
- `in_type`  input  TYPE_W  decoded instruction class.
- `out_valid`  output  1  EX-side entry valid.
- `out_ready`  input  1  EX consumes the entry this cycle.
- `out_inst`, `out_op_a`, `out_op_b`, `out_imm`  output  XLEN each  registered payload.
- `out_type`  output  TYPE_W  registered instruction class.

## Operation
- Transfer in: `in_valid & in_ready` on a rising edge. Transfer out: `out_valid & out_ready`.
- Main entry drives the `out_*` ports directly from registers. There is no combinational path from `in_*` to `out_*`.
- States: EMPTY (no entry), FULL (main entry valid), SKID (main and skid entries valid; only with the skid feature).
- EMPTY + in transfer -> FULL, and the payload loads into the main entry.
- FULL + out transfer + in transfer -> FULL, and the main entry reloads from the input.
- FULL + out transfer, no in transfer -> EMPTY.
- FULL + in transfer, no out transfer -> SKID, and the input loads into the skid entry.
- SKID + out transfer -> FULL, and the skid entry moves to the main entry.
- `in_ready` is 0 in SKID.
- `out_valid` = (state != EMPTY).
- Bubble payload: `out_inst` = `NOP_INST`; `out_op_a`, `out_op_b`, `out_imm` = 0; `out_type` = 0.
- A transition to EMPTY loads the bubble payload into the main entry. Payload never shows stale data while `out_valid` = 0.
- Flush has priority over every other event. The next state is EMPTY, the main entry loads the bubble payload, and the skid entry is discarded. An input presented in the flush cycle is dropped even if `in_ready` was 1.
- An out transfer in the flush cycle still counts as consumed by EX.
- Payload is captured verbatim; no arithmetic or width conversion is performed.

## Timing
- Latency: one cycle from in transfer into an empty stage to `out_valid` = 1.
- Throughput: one entry per cycle while `out_ready` stays high.
- Reset values while `rst` = 1: state EMPTY, `out_valid` 0, `out_inst` `NOP_INST`, `out_op_a`/`out_op_b`/`out_imm` 0, `out_type` 0.
- Reset value of `in_ready`: 1 in the skid build. In the non-skid build it is 1 by its equation while empty.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- `out_*` change only on a rising edge or on assertion of `rst`.
- Once `out_valid` is 1, `out_*` must stay stable until the out transfer or a flush.
- ID must hold `in_*` stable while `in_valid` = 1 and `in_ready` = 0.

## Configuration
- `ID_EX_SKID_EN` defined:
  - Two-entry storage and SKID state are present.
  - `in_ready` is a flop, equal to (next state != SKID).
  - No combinational path from `out_ready` to `in_ready`.
- `ID_EX_SKID_EN` undefined:
  - Single entry; states EMPTY and FULL only.
  - `in_ready` = `out_ready | ~out_valid` (combinational), so a stalled EX stalls ID in the same cycle.
  - All other behaviour is identical.

## Structure
- Package `id_ex_pkg` holds:
  - Default constants `XLEN_D`, `TYPE_W_D`, `NOP_INST_D`.
  - State enum `id_ex_state_e` {EMPTY, FULL, SKID}.
  - Packed struct `id_ex_payload_t` {inst, op_a, op_b, imm, type}.
  - Function `bubble_payload()`.
- One sub-module, `id_ex_slot`: payload register with async reset to the bubble payload and a load enable. It is instantiated once for the main entry and, in the skid build, once for the skid entry.

## Test plan
- Reset release, then `in_valid` with `in_inst`=32'h0020_8133, `in_op_a`=5, `in_op_b`=7 and `out_ready`=1 -> next cycle `out_valid`=1, `out_inst`=32'h0020_8133, `out_op_a`=5, `out_op_b`=7.
- Streaming: 8 back-to-back entries, `out_ready`=1 -> 8 consecutive `out_valid` cycles, in order, with no gaps.
- Back-pressure (skid build): hold `out_ready`=0 while sending A and B. Expected: after B is accepted, `in_ready`=0 and `out` shows A. Raise `out_ready` -> A then B emitted, then `in_ready` returns to 1.
- Flush in SKID state with a new input C presented -> next cycle `out_valid`=0, `out_inst`=32'h0000_0013, C is never emitted, `in_ready`=1.
- Assert `rst` asynchronously while FULL -> `out_valid` falls before the next edge, and all payload outputs equal the bubble values.
- Non-skid build: `out_valid`=1 and `out_ready`=0 -> `in_ready`=0 in the same cycle. Raise `out_ready` -> `in_ready`=1 combinationally.

Source files
------------

// File: rtl/id_ex_pkg.sv
// Shared types and defaults for the ID->EX pipeline stage.
// Optional skid entry is enabled by defining ID_EX_SKID_EN.
package id_ex_pkg;

  localparam int          XLEN_D     = 32;
  localparam int          TYPE_W_D   = 5;
  localparam logic [31:0] NOP_INST_D = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } id_ex_state_e;

  // Source select for the main entry load mux
  typedef enum logic [1:0] {
    SEL_IN     = 2'd0,
    SEL_SKID   = 2'd1,
    SEL_BUBBLE = 2'd2
  } main_sel_e;

  // 'type' is a reserved word, hence inst_type
  typedef struct packed {
    logic [XLEN_D-1:0]   inst;
    logic [XLEN_D-1:0]   op_a;
    logic [XLEN_D-1:0]   op_b;
    logic [XLEN_D-1:0]   imm;
    logic [TYPE_W_D-1:0] inst_type;
  } id_ex_payload_t;

  // Bubble payload for the default-width configuration
  function automatic id_ex_payload_t bubble_payload();
    id_ex_payload_t p;
    p           = '0;
    p.inst      = NOP_INST_D;
    return p;
  endfunction

endpackage

// File: rtl/id_ex_pipe_stage_slot.sv
// id_ex_slot: payload register, async reset to the bubble value, load enable.
module id_ex_slot #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold payload; reload only when the controller asks
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= RST_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID->EX register stage with valid/ready handshake,
// synchronous flush and bubble insertion. Define ID_EX_SKID_EN for a
// second (skid) entry that makes in_ready a pure flop.
//
// state | meaning
// EMPTY | no entry, main entry holds the bubble payload
// FULL  | main entry valid
// SKID  | main and skid entries valid (skid build only)
module id_ex_pipe_stage
  import id_ex_pkg::*;
#(
  parameter int              XLEN     = XLEN_D,
  parameter int              TYPE_W   = TYPE_W_D,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_D)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_inst,
  input  logic [XLEN-1:0]   in_op_a,
  input  logic [XLEN-1:0]   in_op_b,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [TYPE_W-1:0] in_type,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_inst,
  output logic [XLEN-1:0]   out_op_a,
  output logic [XLEN-1:0]   out_op_b,
  output logic [XLEN-1:0]   out_imm,
  output logic [TYPE_W-1:0] out_type
);

  localparam int            PW     = 4 * XLEN + TYPE_W;
  localparam logic [PW-1:0] BUBBLE = {NOP_INST, {(3 * XLEN + TYPE_W){1'b0}}};

  id_ex_state_e  state_q, state_d;
  main_sel_e     main_sel;
  logic          main_load;
  logic          in_fire, out_fire;
  logic [PW-1:0] in_data, main_d, main_q;

  assign in_data  = {in_inst, in_op_a, in_op_b, in_imm, in_type};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_valid = (state_q != EMPTY);
  assign {out_inst, out_op_a, out_op_b, out_imm, out_type} = main_q;

`ifdef ID_EX_SKID_EN
  logic          skid_load;
  logic [PW-1:0] skid_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Next state and entry load controls; flush overrides everything
  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_sel  = SEL_IN;
`ifdef ID_EX_SKID_EN
    skid_load = 1'b0;
`endif
    if (flush) begin
      state_d   = EMPTY;
      main_load = 1'b1;
      main_sel  = SEL_BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = FULL;
            main_load = 1'b1;
          end
        end
        FULL: begin
          if (out_fire && in_fire) begin
            main_load = 1'b1;
          end else if (out_fire) begin
            state_d   = EMPTY;
            main_load = 1'b1;
            main_sel  = SEL_BUBBLE;
          end
`ifdef ID_EX_SKID_EN
          else if (in_fire) begin
            state_d   = SKID;
            skid_load = 1'b1;
          end
`endif
        end
`ifdef ID_EX_SKID_EN
        SKID: begin
          if (out_fire) begin
            state_d   = FULL;
            main_load = 1'b1;
            main_sel  = SEL_SKID;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  // Main entry source mux
  always_comb begin
    main_d = in_data;
    case (main_sel)
      SEL_BUBBLE: main_d = BUBBLE;
`ifdef ID_EX_SKID_EN
      SEL_SKID:   main_d = skid_q;
`endif
      default:    main_d = in_data;
    endcase
  end

  id_ex_slot #(.W(PW), .RST_VAL(BUBBLE)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .d    (main_d),
    .q    (main_q)
  );

`ifdef ID_EX_SKID_EN
  id_ex_slot #(.W(PW), .RST_VAL(BUBBLE)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .d    (in_data),
    .q    (skid_q)
  );

  // Registered ready: low exactly while both entries are occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_ready <= 1'b1;
    else     in_ready <= (state_d != SKID);
  end
`else
  assign in_ready = out_ready | ~out_valid;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Self-checking bench for id_ex_pipe_stage (default or ID_EX_SKID_EN build).
module tb_id_ex_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_op_a, in_op_b, in_imm;
  logic [31:0] out_inst, out_op_a, out_op_b, out_imm;
  logic [4:0]  in_type, out_type;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  ty;
  } ent_t;

  ent_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic last_ready;
  logic last_ov;

  always #5 clk = ~clk;

  id_ex_pipe_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_op_a   (in_op_a),
    .in_op_b   (in_op_b),
    .in_imm    (in_imm),
    .in_type   (in_type),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_op_a  (out_op_a),
    .out_op_b  (out_op_b),
    .out_imm   (out_imm),
    .out_type  (out_type)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Capacity rule: skid build accepts while fewer than two entries held;
  // single-entry build accepts when empty or when EX takes the entry now.
  function automatic logic model_ready(input logic ordy);
`ifdef ID_EX_SKID_EN
    return (q.size() < 2);
`else
    return ordy || (q.size() == 0);
`endif
  endfunction

  task automatic check_outputs(input logic ordy);
    ent_t e;
    e = (q.size() > 0) ? q[0] : '{inst: NOP, a: 32'd0, b: 32'd0, imm: 32'd0, ty: 5'd0};
    check("in_ready",  {31'd0, in_ready},  {31'd0, model_ready(ordy)});
    check("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("out_inst",  out_inst, e.inst);
    check("out_op_a",  out_op_a, e.a);
    check("out_op_b",  out_op_b, e.b);
    check("out_imm",   out_imm,  e.imm);
    check("out_type",  {27'd0, out_type}, {27'd0, e.ty});
  endtask

  // One clock: drive at posedge+1, check at posedge+2, update model at edge
  task automatic step(input logic iv, input ent_t e, input logic ordy, input logic fl);
    logic rdy, ifire, ofire;
    in_valid = iv;
    in_inst = e.inst; in_op_a = e.a; in_op_b = e.b; in_imm = e.imm; in_type = e.ty;
    out_ready = ordy;
    flush = fl;
    #1;
    check_outputs(ordy);
    rdy        = model_ready(ordy);
    last_ready = rdy;
    last_ov    = out_valid;
    ifire      = iv && rdy;
    ofire      = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(e);
    end
    #1;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.inst = $urandom; e.a = $urandom; e.b = $urandom; e.imm = $urandom;
    e.ty   = 5'($urandom_range(0, 31));
    return e;
  endfunction

  initial begin
    ent_t e, ea, eb, ec, cur;
    logic cur_iv;
    int   ov_cnt;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_op_a = '0; in_op_b = '0; in_imm = '0; in_type = '0;
    last_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(1'b0);
    rst = 1'b0;

    // First transfer, directed payload
    e = '{inst: 32'h0020_8133, a: 32'd5, b: 32'd7, imm: 32'd0, ty: 5'd0};
    step(1'b1, e, 1'b1, 1'b0);
    check("first_inst", out_inst, 32'h0020_8133);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);

    // Streaming: 8 back-to-back entries
    ov_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, rnd_ent(), 1'b1, 1'b0);
      if (i > 0) ov_cnt += int'(last_ov);
    end
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
    ov_cnt += int'(last_ov);
    check("stream_valid_cycles", ov_cnt, 8);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);

`ifdef ID_EX_SKID_EN
    // Back-pressure: A and B both accepted, then drained in order
    ea = rnd_ent(); eb = rnd_ent();
    step(1'b1, ea, 1'b0, 1'b0);
    step(1'b1, eb, 1'b0, 1'b0);
    check("bp_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_shows_a", out_inst, ea.inst);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
    check("bp_shows_b", out_inst, eb.inst);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
    // Flush in SKID with C presented
    ec = rnd_ent();
    step(1'b1, rnd_ent(), 1'b0, 1'b0);
    step(1'b1, rnd_ent(), 1'b0, 1'b0);
    step(1'b1, ec, 1'b0, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_inst", out_inst, NOP);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
`else
    // Same-cycle stall propagation
    ea = rnd_ent();
    step(1'b1, ea, 1'b0, 1'b0);
    out_ready = 1'b0; in_valid = 1'b0; #1;
    check("stall_ready_low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1; #1;
    check("stall_ready_high", {31'd0, in_ready}, 32'd1);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
    // Flush while FULL with a new input presented
    step(1'b1, rnd_ent(), 1'b0, 1'b0);
    step(1'b1, rnd_ent(), 1'b1, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_inst", out_inst, NOP);
    step(1'b0, rnd_ent(), 1'b1, 1'b0);
`endif

    // Asynchronous reset while FULL
    step(1'b1, rnd_ent(), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_inst", out_inst, NOP);
    check("arst_op_a", out_op_a, 32'd0);
    check("arst_op_b", out_op_b, 32'd0);
    check("arst_imm",  out_imm,  32'd0);
    check("arst_type", {27'd0, out_type}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_ready = 1'b1;

    // Random traffic; held input stays stable while stalled
    cur_iv = 1'b0;
    cur = rnd_ent();
    for (int i = 0; i < 400; i++) begin
      logic fl;
      if (!(cur_iv && !last_ready)) begin
        cur_iv = ($urandom_range(0, 3) != 0);
        cur    = rnd_ent();
      end
      fl = ($urandom_range(0, 24) == 0);
      step(cur_iv, cur, ($urandom_range(0, 2) != 0), fl);
      if (fl) cur_iv = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
